// File: rtl/bus_watchdog_if.sv
// 68000 bus signals seen by the bus-cycle watchdog: strobes, termination,
// direction and address in from the CPU/decoder side, BERR back to the CPU.
interface bus_watchdog_if #(
  parameter int ADDR_W = 23
);
  logic              as;
  logic              dtack;
  logic              vpa;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic              berr;

  modport master (
    output as, dtack, vpa, rw, addr,
    input  berr
  );

  modport slave (
    input  as, dtack, vpa, rw, addr,
    output berr
  );
endinterface

// File: rtl/bus_watchdog.sv
// Bus-cycle watchdog: asserts BERR when a started 68000 cycle sees no DTACK/VPA
// within TIMEOUT clocks, and latches the faulting address/direction.
module bus_watchdog #(
  parameter int TIMEOUT = 64,
  parameter int ADDR_W  = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clr_fault,
  bus_watchdog_if.slave     bus,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_addr,
  output logic              fault_rw,
  output logic [7:0]        fault_count
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARMED  = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  localparam logic [1:0] BERR_S = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             term;
  logic             to_berr;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    term      = !bus.dtack || !bus.vpa;
    state_nxt = state;
    cnt_nxt   = '0;
    to_berr   = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.as && enable) state_nxt = term ? DONE : ARMED;
      end
      ARMED: begin
        // termination outranks abort/disable, which outrank the timeout
        if (term)                state_nxt = DONE;
        else if (bus.as)         state_nxt = IDLE;
        else if (!enable)        state_nxt = IDLE;
        else if (cnt == CNT_LAST) begin
          state_nxt = BERR_S;
          to_berr   = 1'b1;
        end else                 cnt_nxt = cnt + 1'b1;
      end
      DONE: begin
        if (bus.as) state_nxt = IDLE;
      end
      BERR_S: begin
        if (bus.as) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bus.berr <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bus.berr <= (state_nxt != BERR_S);
    end
  end

  // a timeout on the same edge as clr_fault restarts the tally at one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault       <= 1'b0;
      fault_count <= 8'd0;
      fault_addr  <= '0;
      fault_rw    <= 1'b1;
    end else if (to_berr) begin
      fault       <= 1'b1;
      fault_count <= clr_fault ? 8'd1 : sat_inc8(fault_count);
      fault_addr  <= bus.addr;
      fault_rw    <= bus.rw;
    end else if (clr_fault) begin
      fault       <= 1'b0;
      fault_count <= 8'd0;
    end
  end

endmodule

// File: tb/tb_bus_watchdog.sv
// Directed bench for bus_watchdog with TIMEOUT=8.
module tb_bus_watchdog;
  localparam int TO = 8;
  localparam int AW = 23;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          clr_fault;
  logic          fault;
  logic [AW-1:0] fault_addr;
  logic          fault_rw;
  logic [7:0]    fault_count;

  int n_chk  = 0;
  int n_pass = 0;

  bus_watchdog_if #(.ADDR_W(AW)) bus ();

  bus_watchdog #(.TIMEOUT(TO), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .clr_fault   (clr_fault),
    .bus         (bus),
    .fault       (fault),
    .fault_addr  (fault_addr),
    .fault_rw    (fault_rw),
    .fault_count (fault_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.as    = 1'b1;
    bus.dtack = 1'b1;
    bus.vpa   = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_berr"},  32'(bus.berr),    32'd1);
    chk({tag, "_fault"}, 32'(fault),       32'd0);
    chk({tag, "_cnt"},   32'(fault_count), 32'd0);
    chk({tag, "_addr"},  32'(fault_addr),  32'd0);
    chk({tag, "_rw"},    32'(fault_rw),    32'd1);
  endtask

  // full timeout cycle: E0, eight more edges to BERR, then release
  task automatic timeout_cycle(input logic [AW-1:0] a, input logic r);
    bus.addr = a;
    bus.rw   = r;
    bus.as   = 1'b0;
    tick();
    repeat (TO) tick();
    bus.as = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; clr_fault = 1'b0;
    idle_bus(); bus.rw = 1'b1; bus.addr = '0;
    #2 reset = 1'b0;

    // reset with random inputs
    for (int i = 0; i < 4; i++) begin
      bus.as = 1'($urandom); bus.dtack = 1'($urandom); bus.vpa = 1'($urandom);
      bus.rw = 1'($urandom); bus.addr = AW'($urandom); enable = 1'($urandom);
      clr_fault = 1'($urandom);
      tick();
    end
    chk_reset_vals("rst");
    idle_bus(); enable = 1'b1; clr_fault = 1'b0;
    @(negedge clk) reset = 1'b1;
    tick(); tick();
    chk_reset_vals("rst_rel");

    // normal read terminated by dtack at E0+3
    bus.addr = 23'h000100; bus.rw = 1'b1; bus.as = 1'b0;
    tick();                                   // E0
    chk("rd_e0", 32'(bus.berr), 32'd1);
    tick(); tick();
    bus.dtack = 1'b0;
    tick();                                   // E0+3
    tick();
    idle_bus();
    tick();                                   // E0+5
    repeat (TO) tick();
    chk("rd_berr", 32'(bus.berr), 32'd1);
    chk("rd_fault", 32'(fault), 32'd0);

    // timeout with address capture
    bus.addr = 23'h7F0000; bus.rw = 1'b0; bus.as = 1'b0;
    tick();                                   // E0
    repeat (TO - 1) tick();                   // E0+7
    chk("to_e7", 32'(bus.berr), 32'd1);
    tick();                                   // E0+8
    chk("to_e8", 32'(bus.berr), 32'd0);
    chk("to_addr", 32'(fault_addr), 32'h7F0000);
    chk("to_rw", 32'(fault_rw), 32'd0);
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_cnt", 32'(fault_count), 32'd1);
    tick();                                   // E0+9
    chk("to_e9", 32'(bus.berr), 32'd0);
    bus.as = 1'b1;
    tick();                                   // E0+10
    chk("to_e10", 32'(bus.berr), 32'd1);

    // clr_fault alone
    clr_fault = 1'b1; tick(); clr_fault = 1'b0;
    chk("clr_cnt", 32'(fault_count), 32'd0);
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_addr_kept", 32'(fault_addr), 32'h7F0000);

    // race: dtack at E0+8 beats the timeout, then state holds DONE
    bus.rw = 1'b1; bus.as = 1'b0;
    tick();
    repeat (TO - 1) tick();
    bus.dtack = 1'b0;
    tick();                                   // E0+8
    chk("race_e8", 32'(bus.berr), 32'd1);
    bus.dtack = 1'b1;
    repeat (12) tick();
    chk("race_done", 32'(bus.berr), 32'd1);
    chk("race_fault", 32'(fault), 32'd0);
    bus.as = 1'b1; tick();

    // race lost: dtack at E0+9 comes too late
    bus.as = 1'b0;
    tick();
    repeat (TO) tick();                       // E0+8
    chk("late_e8", 32'(bus.berr), 32'd0);
    bus.dtack = 1'b0;
    tick();                                   // E0+9
    chk("late_e9", 32'(bus.berr), 32'd0);
    idle_bus(); tick();
    chk("late_rel", 32'(bus.berr), 32'd1);
    chk("late_cnt", 32'(fault_count), 32'd1);

    // abort: as rises at E0+4
    bus.as = 1'b0;
    tick();
    repeat (3) tick();
    bus.as = 1'b1;
    tick();
    repeat (12) tick();
    chk("abort_berr", 32'(bus.berr), 32'd1);
    chk("abort_cnt", 32'(fault_count), 32'd1);

    // enable dropped mid-cycle
    bus.as = 1'b0;
    tick(); tick(); tick();
    enable = 1'b0;
    repeat (14) tick();
    chk("dis_berr", 32'(bus.berr), 32'd1);
    bus.as = 1'b1; tick(); enable = 1'b1;

    // enable dropped while in BERR
    bus.addr = 23'h00ABCD; bus.as = 1'b0;
    tick();
    repeat (TO) tick();
    chk("dberr_set", 32'(bus.berr), 32'd0);
    enable = 1'b0;
    repeat (3) tick();
    chk("dberr_hold", 32'(bus.berr), 32'd0);
    bus.as = 1'b1; tick();
    chk("dberr_rel", 32'(bus.berr), 32'd1);
    chk("dberr_cnt", 32'(fault_count), 32'd2);
    enable = 1'b1;

    // vpa termination at E0+2
    bus.as = 1'b0;
    tick(); tick();
    bus.vpa = 1'b0;
    tick();
    bus.vpa = 1'b1;
    repeat (12) tick();
    chk("vpa_berr", 32'(bus.berr), 32'd1);
    bus.as = 1'b1; tick();

    // clr_fault on the BERR entry edge: set wins
    bus.addr = 23'h055555; bus.rw = 1'b0; bus.as = 1'b0;
    tick();
    repeat (TO - 1) tick();
    clr_fault = 1'b1;
    tick();
    clr_fault = 1'b0;
    chk("clrset_berr", 32'(bus.berr), 32'd0);
    chk("clrset_fault", 32'(fault), 32'd1);
    chk("clrset_cnt", 32'(fault_count), 32'd1);
    chk("clrset_addr", 32'(fault_addr), 32'h055555);
    bus.as = 1'b1; tick();

    // saturation over 256 consecutive timeouts
    clr_fault = 1'b1; tick(); clr_fault = 1'b0;
    for (int i = 0; i < 255; i++) timeout_cycle(AW'(i), 1'b1);
    chk("sat_255", 32'(fault_count), 32'd255);
    chk("sat_addr", 32'(fault_addr), 32'd254);
    timeout_cycle(23'h001234, 1'b0);
    chk("sat_hold", 32'(fault_count), 32'd255);
    chk("sat_addr2", 32'(fault_addr), 32'h001234);
    chk("sat_rw", 32'(fault_rw), 32'd0);

    // asynchronous reset while berr is low, then a fresh count from still-low as
    bus.as = 1'b0;
    tick();
    repeat (TO) tick();
    chk("arst_pre", 32'(bus.berr), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk_reset_vals("arst");
    #1 reset = 1'b1;
    tick();                                   // new E0
    repeat (TO - 1) tick();
    chk("arst_e7", 32'(bus.berr), 32'd1);
    tick();
    chk("arst_e8", 32'(bus.berr), 32'd0);
    chk("arst_cnt", 32'(fault_count), 32'd1);
    bus.as = 1'b1; tick();
    chk("arst_rel", 32'(bus.berr), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bus_watchdog.md
# bus_watchdog

Bus-cycle watchdog for the 68000 bus, sitting directly downstream of `mem_decoder`. It consumes the merged `dtack` that `mem_decoder` produces, together with the CPU's `as` and `vpa`. If a started bus cycle is not terminated within a fixed number of clocks, it asserts `berr` to the CPU. It also latches the faulting address and direction for the boot ROM's bus-error handler.

## Interface
Parameters:
- `TIMEOUT`, 64: clocks from AS sampled low to BERR assertion; legal range 2..255.
- `ADDR_W`, 23: width of the captured address (A23..A1).

Ports:
- `clk`  in  1  system clock, same domain as the CPU bus.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  watchdog enable; 1 = active.
- `as`  in  1  CPU address strobe, active-low.
- `dtack`  in  1  merged DTACK from `mem_decoder`, active-low.
- `vpa`  in  1  valid peripheral address / autovector termination, active-low.
- `rw`  in  1  CPU R/W (1 = read).
- `addr`  in  ADDR_W  CPU address A23..A1.
- `clr_fault`  in  1  single-cycle pulse; clears `fault` and `fault_count`.
- `berr`  out  1  bus error to CPU, active-low, registered.
- `fault`  out  1  sticky flag, high after any timeout.
- `fault_addr`  out  ADDR_W  address of the most recent timed-out cycle.
- `fault_rw`  out  1  R/W of the most recent timed-out cycle.
- `fault_count`  out  8  saturating count of timeouts.

## Operation
- All inputs are sampled on the rising edge of `clk`; no internal synchronisers.
- A cycle is terminated when the sampled value of `dtack` = 0 or `vpa` = 0.
- The cycle counter is internal, wide enough for TIMEOUT-1, and is cleared in every state except ARMED.
- FSM states and transitions:
  - IDLE:
    - `as`=0, `enable`=1, terminated → DONE.
    - `as`=0, `enable`=1, not terminated → ARMED, counter = 0.
    - Otherwise stay in IDLE.
  - ARMED, with priority in this order:
    - terminated → DONE;
    - `as`=1 → IDLE (aborted cycle);
    - `enable`=0 → IDLE;
    - counter == TIMEOUT-1 → BERR;
    - else counter += 1.
  - DONE: `as`=1 → IDLE; otherwise stay in DONE.
  - BERR: `berr` held 0; `as`=1 → IDLE, with `berr` returning to 1 on that same edge. `enable` is ignored in this state.
- On the ARMED→BERR edge:
  - `fault_addr` ← `addr`;
  - `fault_rw` ← `rw`;
  - `fault` ← 1;
  - `fault_count` += 1, saturating at 255.
- `clr_fault` clears `fault` and `fault_count` to 0. If it coincides with an ARMED→BERR edge, the set wins: `fault` = 1 and `fault_count` = 1. `fault_addr` and `fault_rw` are not cleared.
- Reset values:
  - state IDLE, counter 0;
  - `berr`=1, `fault`=0, `fault_count`=0, `fault_addr`=0, `fault_rw`=1.
- Reset asserted mid-cycle, including in BERR, forces the reset values immediately and asynchronously. After reset release, a still-low `as` starts a fresh ARMED count on the next edge.

## Timing
- E0 is the first edge that samples `as`=0 in IDLE. With no termination, `berr` goes low exactly at edge E0+TIMEOUT.
- Termination sampled at any edge from E0 through E0+TIMEOUT, inclusive, prevents `berr`. Termination wins over timeout on the same edge.
- Zero-wait cycles, where `dtack` is already low at E0, go IDLE→DONE with no count.
- `berr` stays low until the first edge sampling `as`=1; it releases on that edge.
- Back-to-back cycles: IDLE is re-entered on the edge that samples `as`=1. The next `as`=0 can be sampled on the following edge.
- `fault*` outputs update on the same edge on which `berr` asserts.

## Test plan
All scenarios use TIMEOUT=8.
- Reset: `reset`=0 with random inputs → `berr`=1, `fault`=0, `fault_count`=0, `fault_addr`=0, `fault_rw`=1. Releasing reset with `as`=1 → outputs unchanged.
- Normal ROM read: `as` low at E0, `dtack` low at E0+3, `as` high at E0+5 → `berr` stays 1 throughout; `fault`=0.
- Timeout: `as` low at E0 with `addr`=23'h7F0000, `rw`=0; `dtack` and `vpa` held high → `berr`=0 exactly at E0+8, `fault_addr`=23'h7F0000, `fault_rw`=0, `fault`=1, `fault_count`=1. `as` high at E0+10 → `berr`=1 at E0+10.
- Race: `dtack` goes low exactly at E0+8 → no BERR; state DONE. Repeat with `dtack` low at E0+9 → `berr` asserted at E0+8.
- Abort and disable:
  - `as` rises at E0+4 → IDLE, no BERR.
  - `enable`=0 during a cycle → no BERR.
  - `enable` dropped while in BERR → `berr` held until `as` rises.
  - `vpa`=0 at E0+2 → no BERR.
- Counters:
  - 256 consecutive timeouts → `fault_count`=255, saturated.
  - `clr_fault` alone → `fault_count`=0, `fault`=0.
  - `clr_fault` on a BERR entry edge → `fault_count`=1, `fault`=1.
  - Reset asserted while `berr`=0 → `berr`=1 immediately, without waiting for a clock edge.
